// File: rtl/gsram_scan.sv
// gsram_scan: ROWS x COLS gradient SRAM with random access and raster scan.
// Define GSRAM_CLEAR_EN to add the clr port and the zero-fill CLEAR state.
module gsram_scan #(
  parameter int DW   = 16,
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int RW   = 4,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef GSRAM_CLEAR_EN
  input  logic          clr,
`endif
  input  logic          inmuxsel,
  input  logic [DW-1:0] m2result,
  input  logic [DW-1:0] lutdata,
  input  logic          we,
  input  logic          re,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic          scan_start,
  input  logic          scan_dir,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] scan_row,
  output logic [CW-1:0] scan_col
);
  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW:0]   ROWS_W = (RW+1)'(ROWS);
  localparam logic [CW:0]   COLS_W = (CW+1)'(COLS);
  localparam logic [RW-1:0] RLAST  = RW'(ROWS-1);
  localparam logic [CW-1:0] CLAST  = CW'(COLS-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
`ifdef GSRAM_CLEAR_EN
    S_CLR,
`endif
    S_DONE
  } state_t;

  function automatic logic [AW-1:0] idx(
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  state_t state_q, state_d;
  logic [DW-1:0] mem_q [N];
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          issued_q;

  logic [DW-1:0] wdata;
  logic [AW-1:0] ra_idx, sc_idx;
  logic          ra_ok, sc_last, idle;
  logic          clr_go, clr_st;
  logic          start, ra_on, step;
  logic          wr_step, rd_issue, rd_acc;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  assign wdata   = inmuxsel ? lutdata : m2result;
  assign ra_ok   = ({1'b0, row} < ROWS_W) && ({1'b0, col} < COLS_W);
  assign ra_idx  = idx(row, col);
  assign sc_idx  = idx(row_q, col_q);
  assign sc_last = (row_q == RLAST) && (col_q == CLAST);
  assign idle    = (state_q == S_IDLE);

`ifdef GSRAM_CLEAR_EN
  logic init_q;

  // one automatic zero-fill after every reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    init_q <= 1'b1;
    else if (idle) init_q <= 1'b0;
  end

  assign clr_go = idle && (clr || init_q);
  assign clr_st = (state_q == S_CLR);
`else
  assign clr_go = 1'b0;
  assign clr_st = 1'b0;
`endif

  assign start    = idle && !clr_go && scan_start;
  assign ra_on    = idle && !clr_go && !scan_start;
  assign wr_step  = (state_q == S_WR) && in_valid;
  assign rd_acc   = rvalid_q && out_ready;
  assign rd_issue = (state_q == S_RD) && !issued_q
                    && (!rvalid_q || out_ready);
  assign step     = wr_step || rd_issue || clr_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = scan_dir ? S_RD : S_WR;
`ifdef GSRAM_CLEAR_EN
        if (clr_go) state_d = S_CLR;
`endif
      end
      S_WR:   if (wr_step && sc_last) state_d = S_DONE;
      S_RD:   if (issued_q && rd_acc) state_d = S_DONE;
`ifdef GSRAM_CLEAR_EN
      S_CLR:  if (sc_last) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WR) || (state_q == S_RD) || clr_st;
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      col_q    <= '0;
      issued_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (start || clr_go) begin
        row_q    <= '0;
        col_q    <= '0;
        issued_q <= 1'b0;
      end else if (step) begin
        if (sc_last) begin
          issued_q <= 1'b1;
        end else if (col_q == CLAST) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      unique case (1'b1)
        rd_issue: begin
          rdata_q  <= mem_q[sc_idx];
          rvalid_q <= 1'b1;
        end
        (ra_on && re && !we): begin
          rdata_q  <= ra_ok ? mem_q[ra_idx] : '0;
          rvalid_q <= 1'b1;
        end
        default:
          rvalid_q <= (state_q == S_RD) && rvalid_q && !out_ready;
      endcase
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = sc_idx;
    mem_wd = wdata;
    if (ra_on && we && ra_ok) begin
      mem_we = 1'b1;
      mem_wa = ra_idx;
    end
    if (wr_step) mem_we = 1'b1;
    if (clr_st) begin
      mem_we = 1'b1;
      mem_wd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign scan_row = row_q;
  assign scan_col = col_q;

endmodule

// File: tb/tb_gsram_scan.sv
// tb_gsram_scan: directed checks of random access, scans, backpressure,
// reset mid-scan and (with GSRAM_CLEAR_EN) the zero-fill clear.
module tb_gsram_scan;
  localparam int DW = 16, ROWS = 10, COLS = 10, RW = 4, CW = 4;
  localparam int N = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
`ifdef GSRAM_CLEAR_EN
  logic          clr = 1'b0;
`endif
  logic          inmuxsel = 1'b0;
  logic [DW-1:0] m2result = '0;
  logic [DW-1:0] lutdata = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [RW-1:0] row = '0;
  logic [CW-1:0] col = '0;
  logic          scan_start = 1'b0;
  logic          scan_dir = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid, busy, done;
  logic [RW-1:0] scan_row;
  logic [CW-1:0] scan_col;

  int errs = 0;
  int checks = 0;
  logic [DW-1:0] model [N];

  always #5 clk = ~clk;

  gsram_scan #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef GSRAM_CLEAR_EN
    .clr(clr),
`endif
    .inmuxsel(inmuxsel), .m2result(m2result), .lutdata(lutdata),
    .we(we), .re(re), .row(row), .col(col),
    .scan_start(scan_start), .scan_dir(scan_dir),
    .in_valid(in_valid), .out_ready(out_ready),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .done(done),
    .scan_row(scan_row), .scan_col(scan_col)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
`ifdef GSRAM_CLEAR_EN
    int c = 0;
    while (!done && c < 300) begin
      tick();
      c++;
    end
    chk("init_clear", done, 1);
    foreach (model[i]) model[i] = '0;
    tick();
`endif
  endtask

  task automatic wr(input int r, input int c, input logic sel,
                    input logic [DW-1:0] d);
    row = RW'(r);
    col = CW'(c);
    inmuxsel = sel;
    lutdata  = sel ? d : ~d;
    m2result = sel ? ~d : d;
    we = 1'b1;
    tick();
    we = 1'b0;
    if (r < ROWS && c < COLS) model[r*COLS+c] = d;
  endtask

  task automatic rd(input string tag, input int r, input int c,
                    input logic [DW-1:0] e);
    row = RW'(r);
    col = CW'(c);
    re = 1'b1;
    tick();
    re = 1'b0;
    chk({tag, "_v"}, rvalid, 1);
    chk(tag, rdata, e);
  endtask

  task automatic wscan(input logic sel, input logic [DW-1:0] base,
                       input int inc, input bit tog, input int stop);
    int k = 0;
    int c = 0;
    int early = 0;
    logic [DW-1:0] d;
    scan_dir = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    chk("ws_busy", busy, 1);
    inmuxsel = sel;
    while (k < stop && c < 1000) begin
      d = base + DW'(k * inc);
      in_valid = tog ? logic'(c % 2 == 0) : 1'b1;
      lutdata  = sel ? d : ~d;
      m2result = sel ? ~d : d;
      tick();
      c++;
      if (in_valid) begin
        model[k] = d;
        k++;
      end
      if (done && k < N) early++;
    end
    in_valid = 1'b0;
    chk("ws_count", k, stop);
    if (stop == N) begin
      chk("ws_done", done, 1);
      chk("ws_idle", busy, 0);
      chk("ws_early", early, 0);
    end
  endtask

  task automatic rscan(input int stall_at);
    int idx = 0;
    int cyc = 0;
    int gaps = 0;
    bit seen = 1'b0;
    logic [RW-1:0] r0;
    logic [CW-1:0] c0;
    out_ready = 1'b1;
    scan_dir = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    while (idx < N && cyc < 500) begin
      tick();
      cyc++;
      if (rvalid) begin
        seen = 1'b1;
        chk("rs_data", rdata, model[idx]);
        if (idx == stall_at) begin
          out_ready = 1'b0;
          r0 = scan_row;
          c0 = scan_col;
          chk("bp_row", r0, (idx + 1) / COLS);
          chk("bp_col", c0, (idx + 1) % COLS);
          repeat (5) begin
            tick();
            cyc++;
            chk("bp_hold", rdata, model[idx]);
            chk("bp_rv", rvalid, 1);
            chk("bp_frz_r", scan_row, r0);
            chk("bp_frz_c", scan_col, c0);
          end
          out_ready = 1'b1;
        end
        idx++;
      end else if (seen) begin
        gaps++;
      end
    end
    chk("rs_count", idx, N);
    tick();
    cyc++;
    chk("rs_done", done, 1);
    chk("rs_gaps", gaps, 0);
    chk("rs_cycles", cyc, (stall_at < 0) ? N + 1 : N + 6);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_srow", scan_row, 0);
    chk("rst_scol", scan_col, 0);
    rst_n = 1'b1;
    wait_init();

    wr(3, 7, 1'b0, 16'h1234);
    rd("rd_37", 3, 7, 16'h1234);
    tick();
    chk("rv_idle", rvalid, 0);
    chk("rdata_hold", rdata, 16'h1234);
    wr(9, 9, 1'b1, 16'hBEEF);
    rd("rd_99", 9, 9, 16'hBEEF);
    rd("rd_oor", 10, 2, 16'h0000);
    wr(3, 2, 1'b0, 16'h0A0A);
    wr(12, 0, 1'b0, 16'h5555);
    wr(2, 12, 1'b0, 16'h5555);
    rd("rd_32", 3, 2, 16'h0A0A);
    rd("rd_37b", 3, 7, 16'h1234);
    rd("rd_99b", 9, 9, 16'hBEEF);

    row = 4'd1;
    col = 4'd1;
    inmuxsel = 1'b0;
    m2result = 16'h7777;
    we = 1'b1;
    re = 1'b1;
    tick();
    we = 1'b0;
    re = 1'b0;
    chk("wr_wins_rv", rvalid, 0);
    rd("rd_11", 1, 1, 16'h7777);

    wscan(1'b1, 16'h0000, 1, 1'b1, N);
    tick();
    rscan(-1);
    tick();
    rscan(42);
    tick();

    wscan(1'b0, 16'hA000, 1, 1'b0, 50);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rvalid", rvalid, 0);
    chk("mid_done", done, 0);
    repeat (3) begin
      tick();
      chk("mid_nodone", done, 0);
    end
    rst_n = 1'b1;
`ifdef GSRAM_CLEAR_EN
    wait_init();
`else
    tick();
    chk("mid_post_done", done, 0);
    chk("mid_post_busy", busy, 0);
`endif
    rscan(-1);
    tick();

`ifdef GSRAM_CLEAR_EN
    begin
      int cnt = 0;
      int c = 0;
      wscan(1'b1, 16'hFFFF, 0, 1'b0, N);
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      while (!done && c < 300) begin
        if (busy) cnt++;
        tick();
        c++;
      end
      chk("clr_busy", cnt, N);
      chk("clr_done", done, 1);
      foreach (model[i]) model[i] = '0;
      tick();
      rscan(-1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/gsram_scan.md
Name: gsram_scan

Overview:
- Parametrised 2D gradient SRAM: ROWS x COLS array of DW-bit words, row-major.
- Write-data source muxed between the multiplier-2 result (m2result) and the LUT output (lutdata).
- Adds to single-cell random access:
  - a raster scan engine that streams the whole array in (write scan) or out (read scan) under valid/ready handshake;
  - asynchronous active-low reset of all control state.
- Sits between the multiplier/LUT datapath and the downstream gradient consumer.

Parameters:
- DW, 16, word width.
- ROWS, 10, number of rows (>=1).
- COLS, 10, number of columns (>=1).
- RW, 4, row address width (2^RW >= ROWS).
- CW, 4, column address width (2^CW >= COLS).

Ports:
- clk  in  1  rising-edge clock (the block's only clock).
- rst_n  in  1  reset, asynchronous, active-low.
- inmuxsel  in  1  write source select: 0 = m2result, 1 = lutdata.
- m2result  in  DW  multiplier result write source.
- lutdata  in  DW  LUT write source.
- we  in  1  random-access write strobe.
- re  in  1  random-access read strobe.
- row  in  RW  random-access row.
- col  in  CW  random-access column.
- scan_start  in  1  start scan (sampled only in IDLE).
- scan_dir  in  1  0 = write scan, 1 = read scan (sampled with scan_start).
- in_valid  in  1  write-scan data valid.
- out_ready  in  1  read-scan consumer ready.
- rdata  out  DW  read data.
- rvalid  out  1  rdata valid.
- busy  out  1  scan (or clear) in progress.
- done  out  1  one-cycle pulse when a scan or clear completes.
- scan_row  out  RW  current scan row.
- scan_col  out  CW  current scan column.

Behaviour:
- Reset (rst_n=0, async):
  - FSM->IDLE, rdata=0, rvalid=0, busy=0, done=0, scan_row=0, scan_col=0.
  - Memory contents are not reset. At time zero they are undefined, except when GSRAM_CLEAR_EN is used.
- Write data: wdata = inmuxsel ? lutdata : m2result, combinational.
- IDLE, random access:
  - we=1: mem[row][col] <= wdata at the clock edge.
  - we=0, re=1: rdata <= mem[row][col]; rvalid=1 the next cycle. Latency 1.
  - we=1 and re=1 together: the write wins; no read is issued and rvalid=0.
  - Neither strobe: rvalid=0 and rdata holds its last value.
  - Out-of-range address (row>=ROWS or col>=COLS): writes are dropped; reads return 0 with rvalid=1.
- IDLE, scan start: scan_start=1 loads scan_row=scan_col=0 and goes to SCAN_WR (scan_dir=0) or SCAN_RD (scan_dir=1). Random access in that same cycle is ignored.
- Scan traversal:
  - Each step advances col; on col=COLS-1, col wraps to 0 and row increments.
  - The step at (ROWS-1,COLS-1) is the last.
- SCAN_WR:
  - Each cycle with in_valid=1: mem[scan_row][scan_col] <= wdata, then advance.
  - in_valid=0 stalls with no advance.
  - After the last write: ->DONE.
- SCAN_RD:
  - Output register behaves as a 1-entry skid. A read of the current cell is issued when rvalid=0 or (rvalid & out_ready); rdata/rvalid update the next cycle, and the address advances on issue.
  - rvalid=1 with out_ready=0: rdata and rvalid hold, and no new read is issued.
  - After the last element is accepted (rvalid & out_ready): ->DONE.
  - Full-throughput streaming (out_ready held 1) delivers ROWS*COLS words in ROWS*COLS+1 cycles from start.
- DONE: done=1 for exactly one cycle, busy=0, then ->IDLE.
- busy=1 in SCAN_WR, SCAN_RD and CLEAR.
- we, re and scan_start are ignored while busy.
- Reset mid-scan: the FSM returns to IDLE immediately. Cells already written keep their data; no done pulse is generated.

Optional Feature:
- Macro: GSRAM_CLEAR_EN.
- With it defined:
  - Extra input port clr (1 bit).
  - clr=1 in IDLE enters CLEAR and writes 0 to every cell in raster order, one cell per cycle (ROWS*COLS cycles), then goes to DONE.
  - clr has priority over scan_start and we/re in the same cycle.
  - After reset deassertion, the FSM enters CLEAR automatically once, so memory reads as all-zero.
- Without it: no clr port, no CLEAR state; memory power-up contents are undefined.

Test Plan:
- Random write/read: inmuxsel=0, m2result=16'h1234, we@(3,7), then re@(3,7) -> rvalid=1 and rdata=16'h1234 one cycle after re.
- Source mux and out of range:
  - inmuxsel=1, lutdata=16'hBEEF, we@(9,9); re@(9,9) -> 16'hBEEF.
  - re@(10,2) -> rdata=0, rvalid=1.
  - we@(12,0) -> no cell changes.
- Write scan then read scan:
  - Write scan feeding lutdata=k for k=0..99, with in_valid toggling every other cycle -> done after 100 accepted words.
  - Read scan with out_ready=1 -> rdata sequence 0..99, rvalid continuous, done one cycle after the last accept.
- Backpressure: read scan with out_ready=0 for 5 cycles at element 42 -> rdata holds 42, rvalid stays 1, scan_row/scan_col frozen, no element lost or duplicated.
- Reset mid-scan: rst_n low at element 50 of a write scan -> busy=0, rvalid=0, no done pulse. Cells 0..49 hold their written values; cells 50..99 are unchanged.
- GSRAM_CLEAR_EN build: fill with 16'hFFFF, pulse clr -> busy for 100 cycles, done pulse; every read returns 0.
